cmp_arbiter: RTL and testbench

- Shares one WIDTH-bit magnitude comparator among NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready handshake per requester, and a single registered response channel tagged with the requester id.
- Sits between multiple control agents and the compare datapath, so the datapath is instantiated once instead of per agent.

---
 rtl/cmp_arbiter_pkg.sv | 18 +
 rtl/cmp_unit.sv | 18 +
 rtl/cmp_arbiter.sv | 128 ++++++++++++
 tb/tb_cmp_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arbiter_pkg.sv
// rtl/cmp_arbiter_pkg.sv - shared types and constants for the compare arbiter
package cmp_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_result_t;

endpackage

// File: rtl/cmp_unit.sv
// rtl/cmp_unit.sv - combinational unsigned magnitude compare
module cmp_unit
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      res
);

    always_comb begin
        res.gt = (a > b);
        res.lt = (a < b);
        res.eq = (a == b);
    end

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin sharing of one comparator with a registered response
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_gt,
    output logic                     rsp_lt,
    output logic                     rsp_eq
);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              can_accept;
    logic              xfer;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    cmp_result_t       cmp_res;

    // Walk downward so the requester closest after last wins the final overwrite.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign any_valid = |req_valid;
    assign winner    = rr_pick(req_valid, last_grant);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a   (sel_a),
        .b   (sel_b),
        .res (cmp_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: next_state = xfer ? BUSY : IDLE;
            BUSY, HOLD: begin
                if (!rsp_ready) begin
                    next_state = HOLD;
                end else if (xfer) begin
                    next_state = BUSY;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Grant only when the response register is empty or draining this cycle.
    always_comb begin
        rsp_valid  = (state != IDLE);
        can_accept = !rsp_valid || rsp_ready;
        xfer       = rst_n && any_valid && can_accept;
        req_ready  = '0;
        if (xfer) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            rsp_gt     <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
        end else if (xfer) begin
            last_grant <= winner;
            rsp_id     <= winner;
            rsp_gt     <= cmp_res.gt;
            rsp_lt     <= cmp_res.lt;
            rsp_eq     <= cmp_res.eq;
        end else if (next_state == IDLE) begin
            rsp_id     <= '0;
            rsp_gt     <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - directed and randomized checks of cmp_arbiter
module tb_cmp_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic           rsp_gt;
    logic           rsp_lt;
    logic           rsp_eq;

    int       m_last  = N - 1;
    bit       m_valid = 1'b0;
    int       m_id    = 0;
    bit [2:0] m_flags = 3'b000;
    logic [N-1:0] last_xfer;
    logic [N-1:0] dut_rdy;
    int n_pass  = 0;
    int n_total = 0;

    cmp_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .rsp_eq    (rsp_eq)
    );

    always #5 clk = ~clk;

    function automatic int rr_winner(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit [2:0] ref_cmp(int a, int b);
        return {a > b, a < b, a == b};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, int a, int b);
        req_valid[i]      = 1'b1;
        req_a[i*W +: W]   = W'(a);
        req_b[i*W +: W]   = W'(b);
    endtask

    task automatic drop_xferred();
        req_valid = req_valid & ~last_xfer;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int w;
        bit acc;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        acc     = !m_valid || rsp_ready;
        w       = rr_winner(req_valid, m_last);
        exp_rdy = '0;
        if (rst_n && acc && w >= 0) exp_rdy[w] = 1'b1;
        dut_rdy = req_ready;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_flags", {rsp_gt, rsp_lt, rsp_eq}, m_flags);
        if (m_valid) chk("rsp_id", rsp_id, m_id);
        last_xfer = req_valid & exp_rdy;
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_flags = 0; m_last = N - 1;
        end else if (exp_rdy != '0) begin
            m_valid = 1;
            m_id    = w;
            m_flags = ref_cmp(int'(req_a[w*W +: W]), int'(req_b[w*W +: W]));
            m_last  = w;
        end else if (rsp_ready) begin
            m_valid = 0; m_flags = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        set_req(0, 0, 15);
        set_req(1, 7, 7);
        set_req(2, 15, 0);
        set_req(3, 4, 5);
        repeat (3) cycle();

        rst_n = 1'b1;
        cycle(); chk("first_grant_r0", dut_rdy, 4'b0001);
        cycle(); chk("rr_grant_1", dut_rdy, 4'b0010);
        cycle(); chk("rr_grant_2", dut_rdy, 4'b0100);
        cycle(); chk("rr_grant_3", dut_rdy, 4'b1000);
        cycle(); chk("rr_grant_wrap0", dut_rdy, 4'b0001);
        req_valid = '0;
        repeat (2) cycle();

        set_req(1, 3, 12);
        set_req(3, 10, 2);
        cycle(); chk("bp_grant1", dut_rdy, 4'b0010);
        drop_xferred();
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("bp_ready_zero", dut_rdy, 4'b0000);
            chk("bp_hold_id", rsp_id, 1);
            chk("bp_hold_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b010);
        end
        rsp_ready = 1'b1;
        cycle(); chk("bp_release_grant3", dut_rdy, 4'b1000);
        drop_xferred();
        chk("bp_next_id3", rsp_id, 3);
        chk("bp_next_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
        repeat (2) cycle();

        set_req(1, 5, 5);
        cycle(); chk("fair_grant1", dut_rdy, 4'b0010);
        set_req(0, 1, 2);
        cycle(); chk("fair_wrap_grant0", dut_rdy, 4'b0001);
        drop_xferred();
        cycle(); chk("fair_then_1", dut_rdy, 4'b0010);
        drop_xferred();
        repeat (2) cycle();

        set_req(2, 9, 3);
        cycle(); chk("single_grant2", dut_rdy, 4'b0100);
        drop_xferred();
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_id", rsp_id, 2);
        chk("single_flags", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
        cycle();
        chk("single_done", rsp_valid, 1'b0);

        set_req(3, 6, 1);
        cycle();
        drop_xferred();
        chk("mid_pending", rsp_valid, 1'b1);
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) begin
            cycle();
            chk("mid_dropped", rsp_valid, 1'b0);
        end
        set_req(0, 2, 2); set_req(1, 8, 9); set_req(2, 0, 0); set_req(3, 15, 15);
        cycle(); chk("mid_restart_grant0", dut_rdy, 4'b0001);
        drop_xferred();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 7) == 0)
                        set_req(i, ($urandom_range(0, 1) == 1) ? 15 : 0, ($urandom_range(0, 1) == 1) ? 15 : 0);
                    else
                        set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            cycle();
            drop_xferred();
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
